// File: rtl/id_ex_control_stage_pkg.sv
// Shared RV32IM control types: mux selects, ALU/branch ops, the EX control word
// and the mul/div sequencer states.
package id_ex_control_stage_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
    alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
  } alu_ops_t;

  typedef enum logic [2:0] {
    beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
  } branch_funct3_t;

  typedef enum logic [2:0] {
    f3_add = 3'd0, f3_sll = 3'd1, f3_slt = 3'd2, f3_sltu = 3'd3,
    f3_xor = 3'd4, f3_sr  = 3'd5, f3_or  = 3'd6, f3_and  = 3'd7
  } arith_funct3_t;

  typedef enum logic [2:0] {
    md_mul = 3'd0, md_mulh = 3'd1, md_mulhsu = 3'd2, md_mulhu = 3'd3,
    md_div = 3'd4, md_divu = 3'd5, md_rem    = 3'd6, md_remu  = 3'd7
  } muldiv_funct3_t;

  typedef enum logic {alu1_rs1_out, alu1_pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {
    alu2_i_imm, alu2_u_imm, alu2_b_imm, alu2_s_imm, alu2_j_imm, alu2_rs2_out
  } alumux2_sel_t;
  typedef enum logic {cmp_rs2_out, cmp_i_imm} cmpmux_sel_t;
  typedef enum logic [3:0] {
    rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4,
    rf_lb, rf_lbu, rf_lh, rf_lhu, rf_muldiv
  } regfilemux_sel_t;

  localparam logic [6:0] BASE_FUNCT7 = 7'b0000000;
  localparam logic [6:0] ALT_FUNCT7  = 7'b0100000;
  localparam logic [6:0] M_FUNCT7    = 7'b0000001;

  typedef struct packed {
    rv32i_opcode_t   opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    alu_ops_t        aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alu_1_MUX_sel;
    alumux2_sel_t    alu_2_MUX_sel;
    cmpmux_sel_t     cmp_MUX_sel;
    regfilemux_sel_t regfile_MUX_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      rs1_id;
    logic [4:0]      rs2_id;
    logic [4:0]      rd_id;
    logic            muldiv;
    logic            illegal;
  } rv32i_control_word_m;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_t;

endpackage

// File: rtl/id_ex_control_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX control stage.
interface id_ex_control_stage_if;
  import id_ex_control_stage_pkg::*;

  logic                id_valid;
  logic [31:0]         id_instr;
  logic [31:0]         id_pc;
  logic                stall_in;
  logic                flush;
  logic                md_done;
  rv32i_control_word_m ex_ctrl;
  logic [31:0]         ex_pc;
  logic                ex_valid;
  logic                md_start;
  logic [2:0]          md_op;
  logic                md_abort;
  logic                stall_out;

  modport master (
    output id_valid, id_instr, id_pc, stall_in, flush, md_done,
    input  ex_ctrl, ex_pc, ex_valid, md_start, md_op, md_abort, stall_out
  );

  modport slave (
    input  id_valid, id_instr, id_pc, stall_in, flush, md_done,
    output ex_ctrl, ex_pc, ex_valid, md_start, md_op, md_abort, stall_out
  );
endinterface

// File: rtl/id_ex_control_stage_decoder.sv
// Combinational RV32I(M) decoder: builds the control word, flags illegal
// encodings and squashes writes to x0.
module control_decoder_m
  import id_ex_control_stage_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [31:0]         instr,
  output rv32i_control_word_m ctrl
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    ctrl                 = '0;
    bad                  = 1'b0;
    ctrl.opcode          = rv32i_opcode_t'(instr[6:0]);
    ctrl.funct3          = funct3;
    ctrl.funct7          = funct7;
    ctrl.rs1_id          = instr[19:15];
    ctrl.rs2_id          = instr[24:20];
    ctrl.rd_id           = instr[11:7];
    ctrl.aluop           = alu_add;
    ctrl.cmpop           = branch_funct3_t'(funct3);
    ctrl.alu_1_MUX_sel   = alu1_rs1_out;
    ctrl.alu_2_MUX_sel   = alu2_i_imm;
    ctrl.cmp_MUX_sel     = cmp_rs2_out;
    ctrl.regfile_MUX_sel = rf_alu_out;

    case (ctrl.opcode)
      op_lui: begin
        ctrl.load_regfile    = 1'b1;
        ctrl.regfile_MUX_sel = rf_u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile  = 1'b1;
        ctrl.alu_1_MUX_sel = alu1_pc_out;
        ctrl.alu_2_MUX_sel = alu2_u_imm;
      end
      op_jal: begin
        ctrl.load_regfile    = 1'b1;
        ctrl.alu_1_MUX_sel   = alu1_pc_out;
        ctrl.alu_2_MUX_sel   = alu2_j_imm;
        ctrl.regfile_MUX_sel = rf_pc_plus4;
      end
      op_jalr: begin
        ctrl.load_regfile    = 1'b1;
        ctrl.regfile_MUX_sel = rf_pc_plus4;
        bad                  = (funct3 != 3'd0);
      end
      op_br: begin
        ctrl.alu_1_MUX_sel = alu1_pc_out;
        ctrl.alu_2_MUX_sel = alu2_b_imm;
        bad                = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      op_load: begin
        ctrl.load_regfile = 1'b1;
        ctrl.mem_read     = 1'b1;
        case (funct3)
          3'd0:    ctrl.regfile_MUX_sel = rf_lb;
          3'd1:    ctrl.regfile_MUX_sel = rf_lh;
          3'd2:    ctrl.regfile_MUX_sel = rf_lw;
          3'd4:    ctrl.regfile_MUX_sel = rf_lbu;
          3'd5:    ctrl.regfile_MUX_sel = rf_lhu;
          default: bad = 1'b1;
        endcase
      end
      op_store: begin
        ctrl.mem_write     = 1'b1;
        ctrl.alu_2_MUX_sel = alu2_s_imm;
        bad                = (funct3 > 3'd2);
      end
      op_imm: begin
        ctrl.load_regfile = 1'b1;
        case (arith_funct3_t'(funct3))
          f3_slt: begin
            ctrl.cmpop = blt; ctrl.cmp_MUX_sel = cmp_i_imm; ctrl.regfile_MUX_sel = rf_br_en;
          end
          f3_sltu: begin
            ctrl.cmpop = bltu; ctrl.cmp_MUX_sel = cmp_i_imm; ctrl.regfile_MUX_sel = rf_br_en;
          end
          f3_sll: begin
            ctrl.aluop = alu_sll;
            bad        = (funct7 != BASE_FUNCT7);
          end
          f3_sr: begin
            ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            bad        = (funct7 != BASE_FUNCT7) && (funct7 != ALT_FUNCT7);
          end
          default: ctrl.aluop = alu_ops_t'(funct3);
        endcase
      end
      op_reg: begin
        ctrl.load_regfile  = 1'b1;
        ctrl.alu_2_MUX_sel = alu2_rs2_out;
        if (funct7 == M_FUNCT7) begin
          if (ENABLE_M != 0) begin
            ctrl.muldiv          = 1'b1;
            ctrl.regfile_MUX_sel = rf_muldiv;
          end else begin
            bad = 1'b1;
          end
        end else if (funct7 == ALT_FUNCT7) begin
          case (arith_funct3_t'(funct3))
            f3_add:  ctrl.aluop = alu_sub;
            f3_sr:   ctrl.aluop = alu_sra;
            default: bad = 1'b1;
          endcase
        end else if (funct7 == BASE_FUNCT7) begin
          case (arith_funct3_t'(funct3))
            f3_slt:  begin ctrl.cmpop = blt;  ctrl.regfile_MUX_sel = rf_br_en; end
            f3_sltu: begin ctrl.cmpop = bltu; ctrl.regfile_MUX_sel = rf_br_en; end
            f3_sr:   ctrl.aluop = alu_srl;
            default: ctrl.aluop = alu_ops_t'(funct3);
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    // An illegal encoding must not touch architectural state downstream.
    if (bad) begin
      ctrl.illegal      = 1'b1;
      ctrl.load_regfile = 1'b0;
      ctrl.mem_read     = 1'b0;
      ctrl.mem_write    = 1'b0;
      ctrl.muldiv       = 1'b0;
    end
    if (ctrl.rd_id == 5'd0) ctrl.load_regfile = 1'b0;
  end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX pipeline register with stall/flush, plus the mul/div launch sequencer
// that holds the front end while a mul/div op is in flight.
module id_ex_control_stage
  import id_ex_control_stage_pkg::*;
#(
  parameter int ENABLE_M     = 1,
  parameter int MD_FIXED_LAT = 0
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_control_stage_if.slave bus
);

  localparam int CNT_W = (MD_FIXED_LAT > 0) ? $clog2(MD_FIXED_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MD_FIXED_LAT > 0) ? MD_FIXED_LAT - 1 : 0);

  rv32i_control_word_m dec_ctrl;
  md_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                advance;
  logic                complete;

  control_decoder_m #(.ENABLE_M(ENABLE_M)) u_decoder (
    .instr (bus.id_instr),
    .ctrl  (dec_ctrl)
  );

  assign advance = !bus.stall_in && !bus.stall_out;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= '0;
      bus.ex_pc    <= '0;
    end else if (bus.flush) begin
      bus.ex_valid             <= 1'b0;
      bus.ex_ctrl.load_regfile <= 1'b0;
      bus.ex_ctrl.mem_read     <= 1'b0;
      bus.ex_ctrl.mem_write    <= 1'b0;
      bus.ex_ctrl.muldiv       <= 1'b0;
    end else if (advance) begin
      bus.ex_valid <= bus.id_valid;
      bus.ex_ctrl  <= dec_ctrl;
      bus.ex_pc    <= bus.id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fixed-latency mode ignores md_done entirely.
  if (MD_FIXED_LAT == 0) begin : g_handshake
    assign complete = (state_q == BUSY) && bus.md_done;
  end else begin : g_fixed
    assign complete = (state_q == BUSY) && (cnt_q == CNT_LAST);
  end

  assign bus.md_start  = (state_q == IDLE) && bus.ex_valid && bus.ex_ctrl.muldiv && !bus.flush;
  assign bus.stall_out = (bus.md_start || ((state_q == BUSY) && !complete)) && !bus.flush;
  assign bus.md_abort  = (state_q == BUSY) && bus.flush && !rst;
  assign bus.md_op     = bus.ex_ctrl.funct3;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.md_start) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (complete) begin
          // DONE parks a finished op that is still held in EX by stall_in.
          state_d = advance ? IDLE : DONE;
          cnt_d   = '0;
        end else if (MD_FIXED_LAT > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.flush || advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Scoreboard bench: three configurations (handshake M, no-M, fixed-latency M)
// share one ID stimulus; expectations are queued per cycle and checked by a monitor.
module tb_id_ex_control_stage;
  import id_ex_control_stage_pkg::*;

  localparam int HS  = 0;
  localparam int NOM = 1;
  localparam int FIX = 2;

  typedef enum int {
    F_VALID, F_LOAD_RF, F_ILLEGAL, F_MEM_RD, F_MEM_WR, F_ALUOP, F_ALU2, F_RF_SEL,
    F_RD, F_PC, F_MULDIV, F_MD_START, F_MD_OP, F_MD_ABORT, F_STALL
  } fld_e;

  typedef struct {
    int          dut;
    int          cyc;
    fld_e        fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        stall_in;
  logic        flush;
  logic        md_done;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done_flag = 1'b0;
  bit   drained = 1'b0;
  exp_t exp_q[$];

  id_ex_control_stage_if b0 ();
  id_ex_control_stage_if b1 ();
  id_ex_control_stage_if b2 ();

  assign b0.id_valid = id_valid; assign b1.id_valid = id_valid; assign b2.id_valid = id_valid;
  assign b0.id_instr = id_instr; assign b1.id_instr = id_instr; assign b2.id_instr = id_instr;
  assign b0.id_pc    = id_pc;    assign b1.id_pc    = id_pc;    assign b2.id_pc    = id_pc;
  assign b0.stall_in = stall_in; assign b1.stall_in = stall_in; assign b2.stall_in = stall_in;
  assign b0.flush    = flush;    assign b1.flush    = flush;    assign b2.flush    = flush;
  assign b0.md_done  = md_done;  assign b1.md_done  = md_done;  assign b2.md_done  = md_done;

  id_ex_control_stage #(.ENABLE_M(1), .MD_FIXED_LAT(0)) u_hs  (.clk(clk), .rst(rst), .bus(b0));
  id_ex_control_stage #(.ENABLE_M(0), .MD_FIXED_LAT(0)) u_nom (.clk(clk), .rst(rst), .bus(b1));
  id_ex_control_stage #(.ENABLE_M(1), .MD_FIXED_LAT(3)) u_fix (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input rv32i_control_word_m c, input logic v,
                                       input logic st, input logic [2:0] op,
                                       input logic ab, input logic sl,
                                       input logic [31:0] pc, input fld_e f);
    case (f)
      F_VALID:    return 32'(v);
      F_LOAD_RF:  return 32'(c.load_regfile);
      F_ILLEGAL:  return 32'(c.illegal);
      F_MEM_RD:   return 32'(c.mem_read);
      F_MEM_WR:   return 32'(c.mem_write);
      F_ALUOP:    return 32'(c.aluop);
      F_ALU2:     return 32'(c.alu_2_MUX_sel);
      F_RF_SEL:   return 32'(c.regfile_MUX_sel);
      F_RD:       return 32'(c.rd_id);
      F_PC:       return pc;
      F_MULDIV:   return 32'(c.muldiv);
      F_MD_START: return 32'(st);
      F_MD_OP:    return 32'(op);
      F_MD_ABORT: return 32'(ab);
      default:    return 32'(sl);
    endcase
  endfunction

  function automatic logic [31:0] observe(input int d, input fld_e f);
    case (d)
      HS:      return pick(b0.ex_ctrl, b0.ex_valid, b0.md_start, b0.md_op, b0.md_abort, b0.stall_out, b0.ex_pc, f);
      NOM:     return pick(b1.ex_ctrl, b1.ex_valid, b1.md_start, b1.md_op, b1.md_abort, b1.stall_out, b1.ex_pc, f);
      default: return pick(b2.ex_ctrl, b2.ex_valid, b2.md_start, b2.md_op, b2.md_abort, b2.stall_out, b2.ex_pc, f);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        check($sformatf("%s[dut%0d]", exp_q[i].name, exp_q[i].dut),
              observe(exp_q[i].dut, exp_q[i].fld), exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s[dut%0d]: never sampled, due cycle %0d", exp_q[i].name, exp_q[i].dut, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
    if (done_flag && !drained) begin
      foreach (exp_q[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s[dut%0d]: left unchecked", exp_q[i].name, exp_q[i].dut);
      end
      exp_q.delete();
      drained = 1'b1;
    end
  end

  task automatic expect_at(input int d, input int dc, input fld_e f, input logic [31:0] v, input string nm);
    exp_t e;
    e.dut = d; e.cyc = cyc + dc; e.fld = f; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD_RST = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_SUB     = 32'h402081B3;  // sub x3,x1,x2
  localparam logic [31:0] I_NOP     = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] I_ONES    = 32'hFFFFFFFF;
  localparam logic [31:0] I_SRAI_BD = 32'h2010D093;  // srai-like, funct7=0x10
  localparam logic [31:0] I_LD_BAD  = 32'h00013083;  // load funct3=3
  localparam logic [31:0] I_LW      = 32'h00012083;  // lw x1,0(x2)
  localparam logic [31:0] I_MUL     = 32'h027302B3;  // mul x5,x6,x7
  localparam logic [31:0] I_DIVU    = 32'h0272D2B3;  // divu x5,x5,x7
  localparam logic [31:0] I_ADD8    = 32'h00208433;  // add x8,x1,x2

  initial begin
    rst = 1'b1; id_valid = 1'b1; id_instr = I_ADD_RST; id_pc = 32'h0;
    stall_in = 1'b0; flush = 1'b0; md_done = 1'b0;

    // Reset holds for two edges with a live instruction at ID.
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      expect_at(d, 0, F_VALID,    0, "rst_ex_valid");
      expect_at(d, 0, F_LOAD_RF,  0, "rst_load_rf");
      expect_at(d, 0, F_STALL,    0, "rst_stall_out");
      expect_at(d, 0, F_MD_START, 0, "rst_md_start");
    end
    rst = 1'b0; id_instr = I_SUB; id_pc = 32'h0000_0100;

    tick();
    expect_at(HS, 0, F_VALID,   1, "sub_valid");
    expect_at(HS, 0, F_ALUOP,   32'(alu_sub), "sub_aluop");
    expect_at(HS, 0, F_ALU2,    32'(alu2_rs2_out), "sub_alu2");
    expect_at(HS, 0, F_LOAD_RF, 1, "sub_load_rf");
    expect_at(HS, 0, F_RD,      3, "sub_rd");
    expect_at(HS, 0, F_PC,      32'h0000_0100, "sub_pc");
    id_instr = I_NOP;

    tick();
    expect_at(HS, 0, F_LOAD_RF, 0, "x0_load_rf");
    expect_at(HS, 0, F_ILLEGAL, 0, "x0_illegal");
    id_instr = I_ONES;

    tick();
    expect_at(HS, 0, F_ILLEGAL, 1, "ones_illegal");
    expect_at(HS, 0, F_MEM_WR,  0, "ones_mem_write");
    expect_at(HS, 0, F_LOAD_RF, 0, "ones_load_rf");
    id_instr = I_SRAI_BD;

    tick();
    expect_at(HS, 0, F_ILLEGAL, 1, "srai_f7_illegal");
    expect_at(HS, 0, F_LOAD_RF, 0, "srai_f7_load_rf");
    id_instr = I_LD_BAD;

    tick();
    expect_at(HS, 0, F_ILLEGAL, 1, "ld_f3_illegal");
    expect_at(HS, 0, F_MEM_RD,  0, "ld_f3_mem_read");
    id_instr = I_LW;

    tick();
    expect_at(HS, 0, F_ILLEGAL, 0, "lw_illegal");
    expect_at(HS, 0, F_MEM_RD,  1, "lw_mem_read");
    expect_at(HS, 0, F_RF_SEL,  32'(rf_lw), "lw_rf_sel");
    id_instr = I_MUL;

    // MUL in EX: handshake unit completes on md_done five cycles after launch.
    tick();
    expect_at(HS, 0, F_MD_START, 1, "mul_start");
    expect_at(HS, 0, F_MD_OP,    32'(md_mul), "mul_op");
    expect_at(HS, 0, F_STALL,    1, "mul_stall_launch");
    expect_at(HS, 0, F_RF_SEL,   32'(rf_muldiv), "mul_rf_sel");
    expect_at(HS, 0, F_MULDIV,   1, "mul_muldiv");
    for (int k = 1; k <= 4; k++) begin
      expect_at(HS, k, F_MD_START, 0, "mul_no_restart");
      expect_at(HS, k, F_STALL,    1, "mul_stall_busy");
    end
    expect_at(HS, 5, F_MD_START, 0, "mul_done_no_start");
    expect_at(HS, 5, F_STALL,    0, "mul_done_stall");
    expect_at(HS, 6, F_VALID,    1, "mul_next_valid");
    expect_at(HS, 6, F_RD,       8, "mul_next_rd");
    expect_at(HS, 6, F_MD_START, 0, "mul_next_start");
    expect_at(NOM, 0, F_ILLEGAL,  1, "nom_mul_illegal");
    expect_at(NOM, 0, F_LOAD_RF,  0, "nom_mul_load_rf");
    expect_at(NOM, 0, F_MD_START, 0, "nom_mul_start");
    expect_at(NOM, 0, F_STALL,    0, "nom_mul_stall");
    expect_at(NOM, 1, F_RD,       8, "nom_next_rd");
    expect_at(NOM, 1, F_MD_START, 0, "nom_next_start");
    id_instr = I_ADD8;
    for (int k = 1; k <= 5; k++) tick();
    md_done = 1'b1;
    tick();
    md_done = 1'b0;

    // DIVU, fixed latency 3: exactly three stall cycles and a single launch.
    rst = 1'b1;
    tick();
    rst = 1'b0; id_instr = I_DIVU;
    tick();
    expect_at(FIX, 0, F_MD_START, 1, "divu_start");
    expect_at(FIX, 0, F_MD_OP,    32'(md_divu), "divu_op");
    expect_at(FIX, 0, F_STALL,    1, "divu_stall0");
    expect_at(FIX, 1, F_STALL,    1, "divu_stall1");
    expect_at(FIX, 2, F_STALL,    1, "divu_stall2");
    expect_at(FIX, 3, F_STALL,    0, "divu_stall3");
    for (int k = 1; k <= 4; k++) expect_at(FIX, k, F_MD_START, 0, "divu_no_restart");
    expect_at(FIX, 4, F_VALID, 1, "divu_next_valid");
    expect_at(FIX, 4, F_RD,    8, "divu_next_rd");
    id_instr = I_ADD8;
    for (int k = 1; k <= 4; k++) tick();

    // stall_in held across completion: op parks in DONE and must not relaunch.
    rst = 1'b1;
    tick();
    rst = 1'b0; id_instr = I_DIVU;
    tick();
    stall_in = 1'b1; id_instr = I_ADD8;
    expect_at(FIX, 0, F_MD_START, 1, "hold_start");
    expect_at(FIX, 3, F_STALL,    0, "hold_complete_stall");
    for (int k = 1; k <= 6; k++) expect_at(FIX, k, F_MD_START, 0, "hold_no_restart");
    expect_at(FIX, 4, F_STALL, 0, "hold_done_stall");
    expect_at(FIX, 4, F_RD,    5, "hold_ex_rd_a");
    expect_at(FIX, 5, F_RD,    5, "hold_ex_rd_b");
    expect_at(FIX, 6, F_RD,    8, "hold_release_rd");
    for (int k = 1; k <= 5; k++) tick();
    stall_in = 1'b0;
    tick();

    // Flush while BUSY in handshake mode.
    rst = 1'b1;
    tick();
    rst = 1'b0; id_instr = I_MUL;
    tick();
    id_instr = I_ADD8;
    expect_at(HS, 0, F_MD_START, 1, "fl_start");
    expect_at(HS, 1, F_MD_ABORT, 0, "fl_no_abort_busy");
    expect_at(HS, 1, F_STALL,    1, "fl_stall_busy");
    expect_at(HS, 2, F_MD_ABORT, 1, "fl_abort");
    expect_at(HS, 2, F_STALL,    0, "fl_stall_flush");
    expect_at(HS, 2, F_MD_START, 0, "fl_start_flush");
    expect_at(HS, 3, F_VALID,    0, "fl_ex_valid");
    expect_at(HS, 3, F_MD_START, 0, "fl_start_after");
    expect_at(HS, 3, F_MD_ABORT, 0, "fl_abort_after");
    expect_at(HS, 4, F_VALID,    1, "fl_next_valid");
    expect_at(HS, 4, F_RD,       8, "fl_next_rd");
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Reset while BUSY returns to IDLE without an abort.
    id_instr = I_MUL;
    tick();
    expect_at(HS, 0, F_MD_START, 1, "rb_start");
    tick();
    rst = 1'b1;
    expect_at(HS, 0, F_MD_ABORT, 0, "rb_no_abort");
    tick();
    rst = 1'b0; id_valid = 1'b0;
    expect_at(HS, 0, F_VALID,    0, "rb_ex_valid");
    expect_at(HS, 0, F_STALL,    0, "rb_stall");
    expect_at(HS, 0, F_MD_START, 0, "rb_start_after");

    tick(); tick(); tick();
    done_flag = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/id_ex_control_stage.md
Name: id_ex_control_stage

Overview:
- RV32IM decode plus ID/EX pipeline register for the pipelined core.
- Decodes the ID-stage instruction into rv32i_control_word_m (RV32I, optional M extension) and registers it for EX.
- Applies stall/flush, filters illegal encodings, suppresses x0 writes.
- Sequences a mul/div unit in either handshake or fixed-latency mode, stalling the front end while the op is busy.

Parameters:
ENABLE_M, 1, 1 decodes M-extension (op_reg, funct7=7'b0000001); 0 flags those encodings illegal
MD_FIXED_LAT, 0, 0 = completion signalled by md_done; N>0 = completion after N BUSY cycles, md_done ignored

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_instr  in  32  instruction word in ID
id_pc  in  32  PC of id_instr
stall_in  in  1  external hold (hazard unit / memory)
flush  in  1  squash ID/EX contents
md_done  in  1  mul/div result ready (handshake mode)
ex_ctrl  out  rv32i_control_word_m  registered control word
ex_pc  out  32  registered PC
ex_valid  out  1  ex_ctrl is a live instruction
md_start  out  1  one-cycle mul/div launch
md_op  out  3  ex_ctrl.funct3 (mul..remu)
md_abort  out  1  in-flight mul/div cancelled
stall_out  out  1  hold IF/ID and ID/EX

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Decode (combinational), same base semantics as the single-issue control:
  - lui: regfilemux imm. auipc/jal/jalr/br/load/store: ALU add with the usual mux selects.
  - op_imm/op_reg: funct3 arithmetic. slt/sltu go through the comparator to br_en.
  - sr: funct7[5] selects sra. op_reg add: funct7[5] selects sub.
- M op (ENABLE_M=1): load_regfile=1, regfile_MUX_sel=regfilemux::muldiv, muldiv=1.
- Illegal, which sets illegal=1 and clears load_regfile/mem_read/mem_write/muldiv:
  - unknown opcode
  - op_reg funct7 not in {0x00, 0x20, 0x01 when M enabled}
  - funct7=0x20 with funct3 not add/sr
  - op_imm sll with funct7≠0; op_imm sr with funct7 not in {0x00, 0x20}
  - load funct3 ∈ {3,6,7}; store funct3>2; branch funct3 ∈ {2,3}; jalr funct3≠0
- rd_id==0 forces load_regfile=0.
- advance = !stall_in && !stall_out.
- Register update priority at each edge:
  1. rst: ex_valid=0, ex_ctrl=all-zero NOP, ex_pc=0, FSM=IDLE, counter=0.
  2. flush: ex_valid=0, ex_ctrl write enables and muldiv cleared.
  3. advance: load decode; ex_valid=id_valid.
  4. otherwise hold.
- Outputs after reset: md_start=0, md_abort=0, stall_out=0.
- FSM states IDLE, BUSY, DONE:
  - md_start = IDLE && ex_valid && ex_ctrl.muldiv && !flush.
  - IDLE→BUSY on md_start; counter cleared.
  - complete = BUSY && (MD_FIXED_LAT==0 ? md_done : cnt==MD_FIXED_LAT-1). cnt increments each BUSY cycle.
  - BUSY on complete: →IDLE if advance, else →DONE. DONE blocks re-issue of the same op under stall_in. DONE→IDLE on advance.
  - stall_out = (md_start || (BUSY && !complete)) && !flush.
  - Fixed mode gives exactly MD_FIXED_LAT stall cycles.
- Flush in BUSY or DONE: md_abort=1 (combinational, BUSY only), next state IDLE, counter cleared.
- md_done outside BUSY is ignored.
- rst mid-BUSY: IDLE, no md_abort.
- Counter width $clog2(MD_FIXED_LAT+1), minimum 1. Zero wrap never occurs.

Decomposition:
- rv32i_types additions:
  - regfilemux::muldiv
  - constant M_FUNCT7=7'b0000001
  - muldiv_funct3_t (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
  - rv32i_control_word_m (existing fields + muldiv, illegal)
  - md_state_t {IDLE, BUSY, DONE}
- Sub-module control_decoder_m (combinational decode, ENABLE_M parameter). Register and FSM live in the top.

Test Plan:
- Reset: rst=1 two cycles, id_valid=1, id_instr=0x002081B3 → ex_valid=0, ex_ctrl.load_regfile=0, stall_out=0, md_start=0.
- SUB x3,x1,x2 (0x402081B3), id_valid=1 → next cycle: ex_valid=1, aluop=alu_sub, alu_2_MUX_sel=rs2_out, load_regfile=1, rd_id=3.
- Illegal and x0 handling:
  - ADDI x0,x0,0 (0x00000013) → load_regfile=0, illegal=0.
  - 0xFFFFFFFF → illegal=1, mem_write=0, load_regfile=0.
  - SRAI with funct7=0x10 → illegal=1.
- MUL x5,x6,x7 (0x027302B3), ENABLE_M=1, MD_FIXED_LAT=0, md_done at +5:
  - one md_start pulse, md_op=0
  - stall_out high until md_done cycle; following ADD enters EX next edge.
  - Same instr with ENABLE_M=0 → illegal=1, md_start never.
- DIVU (0x0272D2B3), MD_FIXED_LAT=3: stall_out high exactly 3 cycles, single md_start.
- Corner cases:
  - stall_in=1 across completion → state DONE, no second md_start.
  - flush in BUSY → md_abort=1, stall_out=0 that cycle, ex_valid=0 next.
